sum_bcd_display: RTL and testbench

- Downstream consumer of the 9-bit adder sum S_0.
- Converts the unsigned sum (0..511) to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives the board's 4-digit, active-low, multiplexed seven-segment display.
- Sits between the combinational adder and the FPGA display pins.

---
 rtl/sum_bcd_display.sv | 191 +++++++++++++++++++
 tb/tb_sum_bcd_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_display.sv
// ============================================================================
//  Module   : sum_bcd_display
//  Purpose  : Sequential double-dabble conversion of the adder sum to BCD,
//             shown on a 4-digit active-low multiplexed 7-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_bcd_display #(
   parameter int IN_W          = 9,
   parameter int REFRESH_DIV   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] sum_in,
   output logic            busy,
   output logic [11:0]     bcd,
   output logic            bcd_valid,
   output logic [3:0]      an,
   output logic [6:0]      seg,
   output logic            dp
);

   localparam int c_SH_W  = 12 + IN_W;
   localparam int c_CNT_W = $clog2(IN_W + 1);
   localparam int c_REF_W = $clog2(REFRESH_DIV);

   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(IN_W - 1);
   localparam logic [c_REF_W-1:0] c_REF_MAX  = c_REF_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_SH_W-1:0]   r_sh;
   logic [c_SH_W-1:0]   w_adj;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [IN_W-1:0]     r_cap;
   logic [IN_W-1:0]     r_last;
   logic                r_pending;
   logic                r_busy;
   logic [11:0]         r_bcd;
   logic                r_bcd_valid;
   logic                w_start;

   logic [c_REF_W-1:0]  r_ref;
   logic [1:0]          r_idx;
   logic [1:0]          w_idx_nxt;
   logic [3:0]          r_an;
   logic [6:0]          r_seg;
   logic [3:0]          w_an_nxt;
   logic [6:0]          w_seg_nxt;
   logic [3:0]          w_digit;
   logic                w_dark;

   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      case (d)
         4'd0:    f_glyph = 7'b1000000;
         4'd1:    f_glyph = 7'b1111001;
         4'd2:    f_glyph = 7'b0100100;
         4'd3:    f_glyph = 7'b0110000;
         4'd4:    f_glyph = 7'b0011001;
         4'd5:    f_glyph = 7'b0010010;
         4'd6:    f_glyph = 7'b0000010;
         4'd7:    f_glyph = 7'b1111000;
         4'd8:    f_glyph = 7'b0000000;
         4'd9:    f_glyph = 7'b0010000;
         default: f_glyph = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction on every BCD nibble before the shift.
   always_comb begin
      w_adj = r_sh;
      for (int k = 0; k < 3; k++) begin
         if (w_adj[IN_W+4*k +: 4] >= 4'd5)
            w_adj[IN_W+4*k +: 4] = w_adj[IN_W+4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_start     = r_pending || (sum_in != r_last);
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sh        <= '0;
         r_cnt       <= '0;
         r_cap       <= '0;
         r_last      <= '0;
         r_pending   <= 1'b1;
         r_busy      <= 1'b0;
         r_bcd       <= 12'h000;
         r_bcd_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_sh      <= {12'b0, sum_in};
                  r_cap     <= sum_in;
                  r_cnt     <= '0;
                  r_pending <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_sh  <= w_adj << 1;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               r_bcd       <= r_sh[c_SH_W-1:IN_W];
               r_last      <= r_cap;
               r_bcd_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Display slot to be shown after the next refresh wrap.
   assign w_idx_nxt = r_idx + 2'd1;

   always_comb begin
      w_digit = 4'd0;
      w_dark  = 1'b1;
      case (w_idx_nxt)
         2'd0: begin
            w_digit = r_bcd[3:0];
            w_dark  = 1'b0;
         end
         2'd1: begin
            w_digit = r_bcd[7:4];
            w_dark  = BLANK_LEADING && (r_bcd[11:4] == 8'h00);
         end
         2'd2: begin
            w_digit = r_bcd[11:8];
            w_dark  = BLANK_LEADING && (r_bcd[11:8] == 4'h0);
         end
         default: w_dark = 1'b1;
      endcase
      if (!r_bcd_valid)
         w_dark = 1'b1;

      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'b1111111;
      if (!w_dark) begin
         w_an_nxt  = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt = f_glyph(w_digit);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ref <= '0;
         r_idx <= 2'd0;
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
      end else if (r_ref == c_REF_MAX) begin
         r_ref <= '0;
         r_idx <= w_idx_nxt;
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   assign busy      = r_busy;
   assign bcd       = r_bcd;
   assign bcd_valid = r_bcd_valid;
   assign an        = r_an;
   assign seg       = r_seg;
   assign dp        = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sum_bcd_display.sv
// ============================================================================
//  Module   : tb_sum_bcd_display
//  Purpose  : Scoreboard bench for sum_bcd_display (blanking on and off).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_bcd_display;

   localparam int IN_W = 9;
   localparam int RDIV = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [IN_W-1:0] sum_in = '0;

   logic        busy_a, bcd_valid_a, dp_a;
   logic [11:0] bcd_a;
   logic [3:0]  an_a;
   logic [6:0]  seg_a;
   logic        busy_b, bcd_valid_b, dp_b;
   logic [11:0] bcd_b;
   logic [3:0]  an_b;
   logic [6:0]  seg_b;

   int          errors = 0;
   int          checks = 0;
   logic [11:0] exp_q[$];
   logic        rst_seen = 1'b0;
   logic        prev_busy = 1'b0;
   logic [11:0] prev_bcd = '0;
   logic [6:0]  glyph_tab [0:9];

   sum_bcd_display #(.IN_W(IN_W), .REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .busy(busy_a), .bcd(bcd_a),
      .bcd_valid(bcd_valid_a), .an(an_a), .seg(seg_a), .dp(dp_a));

   sum_bcd_display #(.IN_W(IN_W), .REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .busy(busy_b), .bcd(bcd_b),
      .bcd_valid(bcd_valid_b), .an(an_b), .seg(seg_b), .dp(dp_b));

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every completed conversion (busy falling) must match the queue head.
   always @(posedge clk) rst_seen <= rst_n;

   always @(negedge clk) begin
      if (rst_seen) begin
         if (prev_busy && !busy_a) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL conv_unexpected: got bcd %0h with empty queue", bcd_a);
            end else begin
               logic [11:0] e;
               e = exp_q.pop_front();
               chk("conv_bcd_a", bcd_a, e);
               chk("conv_bcd_b", bcd_b, e);
               chk("conv_valid", {bcd_valid_a, bcd_valid_b}, 2'b11);
            end
         end else if (bcd_a != prev_bcd) begin
            checks++;
            errors++;
            $display("FAIL bcd_glitch: got %0h expected %0h", bcd_a, prev_bcd);
         end
      end
      prev_busy = busy_a;
      prev_bcd  = bcd_a;
   end

   task automatic wait_done(output int n, output int nbusy, output bit early_valid);
      bit seen;
      seen = 0; n = 0; nbusy = 0; early_valid = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         n++;
         if (busy_a) begin
            seen = 1;
            nbusy++;
            if (bcd_valid_a) early_valid = 1;
         end else if (seen) begin
            return;
         end
      end
      n = 0;
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected busy to fall");
   endtask

   task automatic convert(input int v, input string nm);
      int n, nb;
      bit ev;
      @(negedge clk);
      sum_in = IN_W'(v);
      exp_q.push_back(to_bcd(v));
      wait_done(n, nb, ev);
      chk({nm, "_latency"}, n, 11);
      chk({nm, "_busy_edges"}, nb, 10);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_busy"}, {busy_a, busy_b}, 2'b00);
      chk({nm, "_bcd"}, bcd_a, 12'h000);
      chk({nm, "_valid"}, {bcd_valid_a, bcd_valid_b}, 2'b00);
      chk({nm, "_an"}, {an_a, an_b}, 8'hFF);
      chk({nm, "_seg"}, seg_a, 7'h7F);
      chk({nm, "_dp"}, {dp_a, dp_b}, 2'b11);
   endtask

   task automatic check_disp(input string nm, input int v, input bit bl);
      logic [3:0] d[3];
      logic [2:0] lit, seen;
      logic [3:0] a;
      logic [6:0] s;
      d[0] = 4'(v % 10);
      d[1] = 4'((v / 10) % 10);
      d[2] = 4'(v / 100);
      lit[0] = 1'b1;
      lit[1] = !bl || d[2] != 0 || d[1] != 0;
      lit[2] = !bl || d[2] != 0;
      seen = '0;
      repeat (4 * RDIV) @(posedge clk);
      for (int i = 0; i < 8 * RDIV; i++) begin
         @(posedge clk); #1;
         a = bl ? an_a : an_b;
         s = bl ? seg_a : seg_b;
         case (a)
            4'b1110: begin seen[0] = 1'b1; chk({nm, "_seg0"}, s, glyph_tab[d[0]]); end
            4'b1101: begin seen[1] = 1'b1; chk({nm, "_seg1"}, s, glyph_tab[d[1]]); end
            4'b1011: begin seen[2] = 1'b1; chk({nm, "_seg2"}, s, glyph_tab[d[2]]); end
            4'b1111: chk({nm, "_seg_dark"}, s, 7'h7F);
            default: begin
               checks++;
               errors++;
               $display("FAIL %s_an: got %b expected a legal anode pattern", nm, a);
            end
         endcase
      end
      chk({nm, "_lit_slots"}, seen, lit);
      chk({nm, "_dp"}, bl ? dp_a : dp_b, 1);
   endtask

   initial begin
      int n, nb, last;
      bit ev;
      glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

      // Power-on reset with sum_in = 0
      rst_n  = 1'b0;
      sum_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(to_bcd(0));
      wait_done(n, nb, ev);
      chk("init_latency", n, 11);
      chk("init_busy_edges", nb, 10);
      chk("init_valid_early", ev, 0);
      check_disp("disp0_bl1", 0, 1'b1);
      check_disp("disp0_bl0", 0, 1'b0);

      convert(255, "c255");
      check_disp("disp255", 255, 1'b1);
      convert(510, "c510");
      check_disp("disp510", 510, 1'b1);
      convert(511, "c511");

      // Input changes during the third shift edge; both values must convert in order
      @(negedge clk);
      sum_in = IN_W'(100);
      exp_q.push_back(to_bcd(100));
      exp_q.push_back(to_bcd(37));
      repeat (4) @(posedge clk);
      @(negedge clk);
      sum_in = IN_W'(37);
      wait_done(n, nb, ev);
      wait_done(n, nb, ev);
      chk("c37_latency", n, 11);

      convert(7, "c7");
      check_disp("disp7_bl1", 7, 1'b1);
      check_disp("disp7_bl0", 7, 1'b0);

      // Reset pulse in the middle of a conversion
      @(negedge clk);
      sum_in = IN_W'(42);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset("midreset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(to_bcd(42));
      wait_done(n, nb, ev);
      chk("c42_latency", n, 11);
      chk("c42_valid_early", ev, 0);
      check_disp("disp42", 42, 1'b1);

      last = 42;
      for (int i = 0; i < 12; i++) begin
         int v;
         v = int'($urandom_range(0, 511));
         if (v != last) begin
            convert(v, "rand");
            last = v;
         end
      end
      check_disp("disp_rand", last, 1'b1);

      repeat (5) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
